uart_inst_loader: RTL and testbench

UART_INST_LOADER -- requirements
Module: uart_inst_loader

---
 rtl/uart_loader_pkg.sv | 14 +
 rtl/uart_rx_byte.sv | 99 +++++++++
 rtl/uart_inst_loader.sv | 82 ++++++++
 tb/tb_uart_inst_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and defaults for the UART instruction loader.
// Holds the frame FSM encoding and the default bit time (100 MHz at 9600 baud).
package uart_loader_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 10417;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte/stop-error pulses.
// Pulses are combinational in the stop-sample cycle; no backpressure, every frame is reported once.
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       busy_o,
    output logic       byte_vld_o,
    output logic [7:0] byte_dat_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_sync1, r_sync2, r_rx_prev;
    rx_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit_idx, w_bit_idx_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             w_byte_vld, w_frame_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx_i;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // Edge detection only in IDLE, so a line that falls during STOP is ignored.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_byte_vld    = 1'b0;
        w_frame_err   = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (r_rx_prev && !r_sync2) w_state_nxt = START;
            end
            START: begin
                if (r_cnt == HALF) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = r_sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {r_sync2, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                    w_byte_vld  = r_sync2;
                    w_frame_err = !r_sync2;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy_o      = (r_state != IDLE);
    assign byte_vld_o  = w_byte_vld;
    assign byte_dat_o  = r_shift;
    assign frame_err_o = w_frame_err;

endmodule

// File: rtl/uart_inst_loader.sv
// Loads 32-bit instruction words from a UART stream into memory, little-endian byte lanes.
// we_o pulses one cycle after the 4th stop-bit sample; no backpressure, memory must accept every write.
module uart_inst_loader
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int ADDR_W       = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    input  logic [ADDR_W-1:0] word_count_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              frame_err_o
);

    logic       w_byte_vld, w_frame_err;
    logic [7:0] w_byte_dat;

    logic              r_armed;
    logic [ADDR_W-1:0] r_word_cnt;
    logic [1:0]        r_lane;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic              r_done;
    logic              r_frame_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rx_i       (rx_i),
        .busy_o     (busy_o),
        .byte_vld_o (w_byte_vld),
        .byte_dat_o (w_byte_dat),
        .frame_err_o(w_frame_err)
    );

    // r_armed marks the first post-reset cycle, the only time word_count_i is captured.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_armed     <= 1'b0;
            r_word_cnt  <= '0;
            r_lane      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (!r_armed) begin
                r_armed    <= 1'b1;
                r_word_cnt <= word_count_i;
                r_done     <= (word_count_i == '0);
            end
            if (w_frame_err) r_frame_err <= 1'b1;
            if (r_we) begin
                r_addr <= r_addr + 1'b1;
                if (ADDR_W'(r_addr + 1'b1) == r_word_cnt) r_done <= 1'b1;
            end
            if (w_byte_vld && r_armed && !r_done) begin
                r_wdata[{r_lane, 3'b000} +: 8] <= w_byte_dat;
                r_lane                         <= r_lane + 2'd1;
                if (r_lane == 2'd3) r_we <= 1'b1;
            end
        end
    end

    assign we_o        = r_we;
    assign addr_o      = r_addr;
    assign wdata_o     = r_wdata;
    assign done_o      = r_done;
    assign frame_err_o = r_frame_err;

endmodule

// File: tb/tb_uart_inst_loader.sv
// Self-checking bench for uart_inst_loader: table of directed frames, hand-written corner cases,
// and random byte streams checked against a queue-based word-assembly model.
module tb_uart_inst_loader;

    localparam int CPB = 16;
    localparam int AW  = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          rx_i  = 1'b1;
    logic [AW-1:0] word_count_i = '0;
    logic          we_o;
    logic [AW-1:0] addr_o;
    logic [31:0]   wdata_o;
    logic          busy_o, done_o, frame_err_o;

    uart_inst_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .word_count_i(word_count_i),
        .we_o        (we_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cyc = -1;
    int rel_cyc = 0;
    bit busy_seen = 1'b0;
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    int            wr_cyc_q[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (we_o) begin
            wr_addr_q.push_back(addr_o);
            wr_data_q.push_back(wdata_o);
            wr_cyc_q.push_back(cyc);
        end
        if (done_o && done_cyc < 0) done_cyc = cyc;
        if (busy_o) busy_seen = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [AW-1:0] wc);
        rst_i = 1'b1;
        rx_i = 1'b1;
        word_count_i = wc;
        repeat (3) @(negedge clk_i);
        check("reset_state", {24'd0, we_o, addr_o, wdata_o, busy_o, done_o, frame_err_o}, 64'd0);
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cyc = -1;
        busy_seen = 1'b0;
        rst_i = 1'b0;
        rel_cyc = cyc;
        repeat (2) @(negedge clk_i);
        word_count_i = ~wc;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stop_ok);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            repeat (CPB) @(negedge clk_i);
        end
        rx_i = stop_ok;
        repeat (CPB) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (8) @(negedge clk_i);
    endtask

    task automatic check_writes(input string tag, input int nexp, input logic [31:0] exp_w[$]);
        check({tag, "_nwr"}, 64'(wr_data_q.size()), 64'(nexp));
        for (int i = 0; i < nexp && i < wr_data_q.size(); i++) begin
            check({tag, "_addr"}, 64'(wr_addr_q[i]), 64'(i));
            check({tag, "_data"}, 64'(wr_data_q[i]), 64'(exp_w[i]));
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] wc;
        int            nb;
        logic [95:0]   b;
        logic [11:0]   bad;
        int            exp_nwr;
        logic [63:0]   exp_d;
        logic          exp_done;
        logic          exp_ferr;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [31:0] ew[$];
        logic [7:0]  vb[$];
        tbl[0] = '{wc: 4'd1, nb: 4,  b: 96'h00_20_01_13, bad: 12'h000, exp_nwr: 1,
                   exp_d: {32'h0, 32'h00200113}, exp_done: 1'b1, exp_ferr: 1'b0};
        tbl[1] = '{wc: 4'd2, nb: 12, b: 96'hCC_BB_AA_99_88_77_66_55_44_33_22_11, bad: 12'h000,
                   exp_nwr: 2, exp_d: {32'h88776655, 32'h44332211}, exp_done: 1'b1, exp_ferr: 1'b0};
        tbl[2] = '{wc: 4'd3, nb: 5,  b: 96'hEF_BE_AD_DE_EE, bad: 12'h001, exp_nwr: 1,
                   exp_d: {32'h0, 32'hEFBEADDE}, exp_done: 1'b0, exp_ferr: 1'b1};
        tbl[3] = '{wc: 4'd0, nb: 4,  b: 96'h04_03_02_01, bad: 12'h000, exp_nwr: 0,
                   exp_d: 64'h0, exp_done: 1'b1, exp_ferr: 1'b0};

        for (int v = 0; v < 4; v++) begin
            do_reset(tbl[v].wc);
            if (tbl[v].wc == '0) check("wc0_done_cycle", 64'(done_cyc), 64'(rel_cyc + 1));
            for (int i = 0; i < tbl[v].nb; i++) send_byte(tbl[v].b[i*8 +: 8], !tbl[v].bad[i]);
            repeat (20) @(negedge clk_i);
            ew.delete();
            ew.push_back(tbl[v].exp_d[31:0]);
            ew.push_back(tbl[v].exp_d[63:32]);
            check_writes("tbl", tbl[v].exp_nwr, ew);
            check("tbl_done", 64'(done_o), 64'(tbl[v].exp_done));
            check("tbl_ferr", 64'(frame_err_o), 64'(tbl[v].exp_ferr));
            check("tbl_busy", 64'(busy_o), 64'd0);
            if (tbl[v].exp_done && tbl[v].exp_nwr > 0 && wr_cyc_q.size() > 0)
                check("done_after_last_we", 64'(done_cyc), 64'(wr_cyc_q[wr_cyc_q.size()-1] + 1));
        end

        // Short low glitch: START must abandon it and leave later framing intact.
        do_reset(4'd1);
        rx_i = 1'b0;
        repeat (5) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (40) @(negedge clk_i);
        check("glitch_busy_seen", 64'(busy_seen), 64'd1);
        check("glitch_busy_low", 64'(busy_o), 64'd0);
        check("glitch_nwr", 64'(wr_data_q.size()), 64'd0);
        check("glitch_ferr", 64'(frame_err_o), 64'd0);
        send_byte(8'hA1, 1'b1); send_byte(8'hB2, 1'b1); send_byte(8'hC3, 1'b1); send_byte(8'hD4, 1'b1);
        repeat (20) @(negedge clk_i);
        ew.delete();
        ew.push_back(32'hD4C3B2A1);
        check_writes("glitch_after", 1, ew);

        // Reset in the middle of the third frame discards the partial word.
        do_reset(4'd1);
        send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
        rx_i = 1'b0;
        repeat (40) @(negedge clk_i);
        check("midrst_no_write", 64'(wr_data_q.size()), 64'd0);
        do_reset(4'd1);
        repeat (20) @(negedge clk_i);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        repeat (20) @(negedge clk_i);
        ew.delete();
        ew.push_back(32'h04030201);
        check_writes("midrst", 1, ew);
        check("midrst_done", 64'(done_o), 64'd1);

        // Random streams against a queue model of lane assembly.
        for (int it = 0; it < 4; it++) begin
            int wc, n, nw;
            bit anybad;
            wc = $urandom_range(1, 3);
            n = $urandom_range(4, 14);
            anybad = 1'b0;
            vb.delete();
            do_reset(AW'(wc));
            for (int k = 0; k < n; k++) begin
                logic [7:0] d;
                bit bad;
                d = 8'($urandom);
                bad = ($urandom_range(0, 4) == 0);
                send_byte(d, !bad);
                if (bad) anybad = 1'b1;
                else vb.push_back(d);
            end
            repeat (20) @(negedge clk_i);
            nw = vb.size() / 4;
            if (nw > wc) nw = wc;
            ew.delete();
            for (int j = 0; j < nw; j++)
                ew.push_back({vb[4*j+3], vb[4*j+2], vb[4*j+1], vb[4*j]});
            check_writes("rand", nw, ew);
            check("rand_done", 64'(done_o), 64'((vb.size() / 4) >= wc));
            check("rand_ferr", 64'(frame_err_o), 64'(anybad));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
